// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, micro-step states, opcode classes, ALU code map and the strobe
// bundle produced by the decoder.
package cpu_ctrl_pkg;

  // IR field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  // ALU operation codes that differ from the opcode itself
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_NONE = 5'b00000;

  // Micro-step states
  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  // Execute-sequence families
  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  // Strobe bundle before register-select decoding
  typedef struct packed {
    logic       pc_out;
    logic       inc_pc;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       mdr_read;
    logic       mem_read;
    logic       mem_write;
    logic       y_in;
    logic       zlow_in;
    logic       zhigh_in;
    logic       zlow_out;
    logic       zhigh_out;
    logic       hi_in;
    logic       lo_in;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       illegal;
    logic [4:0] alu_sel;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHL, OP_ROR, OP_ROL:             op_class = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:           op_class = CL_IMM;
      OP_MUL, OP_DIV:                     op_class = CL_MULDIV;
      OP_NEG, OP_NOT:                     op_class = CL_UNARY;
      OP_LD:                              op_class = CL_LD;
      OP_ST:                              op_class = CL_ST;
      OP_NOP:                             op_class = CL_NOP;
      OP_HALT:                            op_class = CL_HALT;
      default:                            op_class = CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT:     alu_code = op;
      OP_ADDI, OP_LD, OP_ST:              alu_code = ALU_ADD;
      OP_ANDI:                            alu_code = ALU_AND;
      OP_ORI:                             alu_code = ALU_OR;
      default:                            alu_code = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sel_encode.sv
// Register select encoder: picks ra/rb/rc from the IR according to
// Gra/Grb/Grc and turns Rin/Rout into one-hot register strobes.
module sel_encode
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic [31:0]      ir,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin,
  input  logic             rout,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out
);

  logic [3:0] sel;

  // Opcode and low immediate bits are not register selectors
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[OPC_HI:OPC_LO], ir[RC_LO-1:0]};

  // Field select, then one-hot decode gated by the direction strobes
  always_comb begin
    sel = 4'd0;
    if (gra)      sel = ir[RA_HI:RA_LO];
    else if (grb) sel = ir[RB_HI:RB_LO];
    else if (grc) sel = ir[RC_HI:RC_LO];
    R_in  = rin  ? (NREGS'(1) << sel) : '0;
    R_out = rout ? (NREGS'(1) << sel) : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch, decode and execute micro-steps, one
// step per clock, stalling in memory wait states until mem_done. Outputs
// decode combinationally from the state register and the live IR, and are
// forced to 0 while clr is high.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_done,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out,
  output logic             PCout,
  output logic             IncPC,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             MDRread,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             ZLowout,
  output logic             ZHighout,
  output logic             HIin,
  output logic             LOin,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             PCin,
  output logic             InPortout,
  output logic [4:0]       ALUselect,
  output logic             run,
  output logic             illegal
);

  state_t     state;
  op_class_t  cls;
  logic [4:0] opcode;
  ctrl_t      c_raw;
  ctrl_t      c;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign cls    = op_class(opcode);

  // Micro-step sequencing; wait states advance only on mem_done
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= T0;
    end else begin
      case (state)
        T0: state <= T1;
        T1: if (mem_done) state <= T2;
        T2: state <= T3;
        T3: begin
          case (cls)
            CL_NOP, CL_ILLEGAL: state <= T0;
            CL_HALT:            state <= HALT;
            default:            state <= T4;
          endcase
        end
        T4: state <= (cls == CL_UNARY) ? T0 : T5;
        T5: state <= (cls == CL_ALU || cls == CL_IMM) ? T0 : T6;
        T6: begin
          case (cls)
            CL_LD:   if (mem_done) state <= T7;
            CL_ST:   state <= T7;
            default: state <= T0;
          endcase
        end
        T7: begin
          if (cls != CL_ST || mem_done) state <= T0;
        end
        HALT:    state <= HALT;
        default: state <= T0;
      endcase
    end
  end

  // Strobe decode for the current micro-step
  always_comb begin
    c_raw = '0;
    case (state)
      T0: begin
        c_raw.pc_out = 1'b1;
        c_raw.mar_in = 1'b1;
        c_raw.inc_pc = 1'b1;
      end
      T1: begin
        c_raw.mem_read = 1'b1;
        c_raw.mdr_read = 1'b1;
        c_raw.mdr_in   = 1'b1;
      end
      T2: begin
        c_raw.mdr_out = 1'b1;
        c_raw.ir_in   = 1'b1;
      end
      T3: begin
        case (cls)
          CL_ALU, CL_IMM, CL_LD, CL_ST: begin
            c_raw.grb   = 1'b1;
            c_raw.r_out = 1'b1;
            c_raw.y_in  = 1'b1;
          end
          CL_MULDIV: begin
            c_raw.gra   = 1'b1;
            c_raw.r_out = 1'b1;
            c_raw.y_in  = 1'b1;
          end
          CL_UNARY: begin
            c_raw.grb     = 1'b1;
            c_raw.r_out   = 1'b1;
            c_raw.zlow_in = 1'b1;
            c_raw.alu_sel = alu_code(opcode);
          end
          CL_ILLEGAL: c_raw.illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CL_ALU: begin
            c_raw.grc     = 1'b1;
            c_raw.r_out   = 1'b1;
            c_raw.zlow_in = 1'b1;
            c_raw.alu_sel = alu_code(opcode);
          end
          CL_IMM, CL_LD, CL_ST: begin
            c_raw.c_out   = 1'b1;
            c_raw.zlow_in = 1'b1;
            c_raw.alu_sel = alu_code(opcode);
          end
          CL_MULDIV: begin
            c_raw.grb      = 1'b1;
            c_raw.r_out    = 1'b1;
            c_raw.zlow_in  = 1'b1;
            c_raw.zhigh_in = 1'b1;
            c_raw.alu_sel  = alu_code(opcode);
          end
          CL_UNARY: begin
            c_raw.zlow_out = 1'b1;
            c_raw.gra      = 1'b1;
            c_raw.r_in     = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CL_ALU, CL_IMM: begin
            c_raw.zlow_out = 1'b1;
            c_raw.gra      = 1'b1;
            c_raw.r_in     = 1'b1;
          end
          CL_MULDIV: begin
            c_raw.zlow_out = 1'b1;
            c_raw.lo_in    = 1'b1;
          end
          CL_LD, CL_ST: begin
            c_raw.zlow_out = 1'b1;
            c_raw.mar_in   = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CL_MULDIV: begin
            c_raw.zhigh_out = 1'b1;
            c_raw.hi_in     = 1'b1;
          end
          CL_LD: begin
            c_raw.mem_read = 1'b1;
            c_raw.mdr_read = 1'b1;
            c_raw.mdr_in   = 1'b1;
          end
          CL_ST: begin
            c_raw.gra    = 1'b1;
            c_raw.r_out  = 1'b1;
            c_raw.mdr_in = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CL_LD: begin
            c_raw.mdr_out = 1'b1;
            c_raw.gra     = 1'b1;
            c_raw.r_in    = 1'b1;
          end
          CL_ST:   c_raw.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // clr blanks every strobe immediately, independent of the clock
  assign c = clr ? '0 : c_raw;

  sel_encode #(.NREGS(NREGS)) u_sel_encode (
    .ir    (ir),
    .gra   (c.gra),
    .grb   (c.grb),
    .grc   (c.grc),
    .rin   (c.r_in),
    .rout  (c.r_out),
    .R_in  (R_in),
    .R_out (R_out)
  );

  assign PCout     = c.pc_out;
  assign IncPC     = c.inc_pc;
  assign IRin      = c.ir_in;
  assign MARin     = c.mar_in;
  assign MDRin     = c.mdr_in;
  assign MDRout    = c.mdr_out;
  assign MDRread   = c.mdr_read;
  assign MemRead   = c.mem_read;
  assign MemWrite  = c.mem_write;
  assign Yin       = c.y_in;
  assign Zlowin    = c.zlow_in;
  assign Zhighin   = c.zhigh_in;
  assign ZLowout   = c.zlow_out;
  assign ZHighout  = c.zhigh_out;
  assign HIin      = c.hi_in;
  assign LOin      = c.lo_in;
  assign HIout     = 1'b0;
  assign LOout     = 1'b0;
  assign Cout      = c.c_out;
  assign PCin      = 1'b0;
  assign InPortout = 1'b0;
  assign ALUselect = c.alu_sel;
  assign illegal   = c.illegal;
  assign run       = ~clr & (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a table of per-cycle input/expected
// records plus hand-written sequences for clr during a wait and fetch timing.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        mem_done;
  logic [15:0] R_in, R_out;
  logic        PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread;
  logic        MemRead, MemWrite, Yin, Zlowin, Zhighin, ZLowout, ZHighout;
  logic        HIin, LOin, HIout, LOout, Cout, PCin, InPortout;
  logic [4:0]  ALUselect;
  logic        run, illegal;

  control_sequencer #(.NREGS(16)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_done(mem_done),
    .R_in(R_in), .R_out(R_out),
    .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Cout(Cout), .PCin(PCin), .InPortout(InPortout),
    .ALUselect(ALUselect), .run(run), .illegal(illegal)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed single-bit outputs packed for comparison
  logic [22:0] obs;
  assign obs = {PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread, MemRead,
                MemWrite, Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIin, LOin,
                HIout, LOout, Cout, PCin, InPortout, run, illegal};

  localparam logic [22:0] M_PCOUT    = 23'(1) << 22;
  localparam logic [22:0] M_INCPC    = 23'(1) << 21;
  localparam logic [22:0] M_IRIN     = 23'(1) << 20;
  localparam logic [22:0] M_MARIN    = 23'(1) << 19;
  localparam logic [22:0] M_MDRIN    = 23'(1) << 18;
  localparam logic [22:0] M_MDROUT   = 23'(1) << 17;
  localparam logic [22:0] M_MDRREAD  = 23'(1) << 16;
  localparam logic [22:0] M_MEMREAD  = 23'(1) << 15;
  localparam logic [22:0] M_MEMWRITE = 23'(1) << 14;
  localparam logic [22:0] M_YIN      = 23'(1) << 13;
  localparam logic [22:0] M_ZLOWIN   = 23'(1) << 12;
  localparam logic [22:0] M_ZHIGHIN  = 23'(1) << 11;
  localparam logic [22:0] M_ZLOWOUT  = 23'(1) << 10;
  localparam logic [22:0] M_ZHIGHOUT = 23'(1) << 9;
  localparam logic [22:0] M_HIIN     = 23'(1) << 8;
  localparam logic [22:0] M_LOIN     = 23'(1) << 7;
  localparam logic [22:0] M_COUT     = 23'(1) << 4;
  localparam logic [22:0] M_RUN      = 23'(1) << 1;
  localparam logic [22:0] M_ILLEGAL  = 23'(1) << 0;

  localparam logic [22:0] S_T0 = M_PCOUT | M_MARIN | M_INCPC | M_RUN;
  localparam logic [22:0] S_T1 = M_MEMREAD | M_MDRREAD | M_MDRIN | M_RUN;
  localparam logic [22:0] S_T2 = M_MDROUT | M_IRIN | M_RUN;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        md;
    logic [22:0] sig;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic logic [15:0] bit16(input int n);
    return 16'(1) << n;
  endfunction

  task automatic add_v(input logic c, input logic [31:0] i, input logic md,
                       input logic [22:0] s, input logic [15:0] ri,
                       input logic [15:0] ro, input logic [4:0] a);
    vec_t v;
    v.clr = c; v.ir = i; v.md = md; v.sig = s; v.rin = ri; v.rout = ro; v.alu = a;
    tbl.push_back(v);
  endtask

  // Fetch: T0, then T1 with 'waits' stalled cycles, then T2
  task automatic add_fetch(input logic [31:0] i, input int waits);
    add_v(1'b0, i, 1'b1, S_T0, '0, '0, '0);
    for (int w = 0; w < waits; w++) add_v(1'b0, i, 1'b0, S_T1, '0, '0, '0);
    add_v(1'b0, i, 1'b1, S_T1, '0, '0, '0);
    add_v(1'b0, i, 1'b0, S_T2, '0, '0, '0);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [22:0] s, input logic [15:0] ri,
                           input logic [15:0] ro, input logic [4:0] a);
    check({tag, " strobes"}, 32'(obs), 32'(s));
    check({tag, " R_in"}, 32'(R_in), 32'(ri));
    check({tag, " R_out"}, 32'(R_out), 32'(ro));
    check({tag, " ALUselect"}, 32'(ALUselect), 32'(a));
  endtask

  initial begin
    logic [31:0] i_add, i_ld, i_mul, i_st, i_neg, i_andi, i_ror, i_nop, i_ill, i_halt;
    int n;

    clr = 1'b1;
    ir = '0;
    mem_done = 1'b0;

    i_add  = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    i_ld   = mk_ir(5'b00000, 4'd5, 4'd6, 4'd0);
    i_mul  = mk_ir(5'b01110, 4'd7, 4'd9, 4'd1);
    i_st   = mk_ir(5'b00010, 4'd4, 4'd8, 4'd0);
    i_neg  = mk_ir(5'b10000, 4'd3, 4'd11, 4'd0);
    i_andi = mk_ir(5'b01100, 4'd2, 4'd13, 4'd0);
    i_ror  = mk_ir(5'b01001, 4'd15, 4'd0, 4'd14);
    i_nop  = mk_ir(5'b11000, 4'd0, 4'd0, 4'd0);
    i_ill  = mk_ir(5'b10101, 4'd6, 4'd6, 4'd6);
    i_halt = mk_ir(5'b11001, 4'd0, 4'd0, 4'd0);

    // Reset held for three cycles
    for (int k = 0; k < 3; k++) add_v(1'b1, i_add, 1'b0, '0, '0, '0, '0);

    // add r1 = r2 + r3, zero-wait fetch
    add_fetch(i_add, 0);
    add_v(1'b0, i_add, 1'b1, M_YIN | M_RUN, '0, bit16(2), '0);
    add_v(1'b0, i_add, 1'b1, M_ZLOWIN | M_RUN, '0, bit16(3), 5'b00011);
    add_v(1'b0, i_add, 1'b1, M_ZLOWOUT | M_RUN, bit16(1), '0, '0);

    // ld r5, (r6+C) with a 2-cycle fetch wait and a 3-cycle data wait
    add_fetch(i_ld, 2);
    add_v(1'b0, i_ld, 1'b0, M_YIN | M_RUN, '0, bit16(6), '0);
    add_v(1'b0, i_ld, 1'b0, M_COUT | M_ZLOWIN | M_RUN, '0, '0, 5'b00011);
    add_v(1'b0, i_ld, 1'b0, M_ZLOWOUT | M_MARIN | M_RUN, '0, '0, '0);
    for (int k = 0; k < 3; k++) add_v(1'b0, i_ld, 1'b0, S_T1, '0, '0, '0);
    add_v(1'b0, i_ld, 1'b1, S_T1, '0, '0, '0);
    add_v(1'b0, i_ld, 1'b0, M_MDROUT | M_RUN, bit16(5), '0, '0);

    // mul r7 * r9
    add_fetch(i_mul, 0);
    add_v(1'b0, i_mul, 1'b1, M_YIN | M_RUN, '0, bit16(7), '0);
    add_v(1'b0, i_mul, 1'b1, M_ZLOWIN | M_ZHIGHIN | M_RUN, '0, bit16(9), 5'b01110);
    add_v(1'b0, i_mul, 1'b1, M_ZLOWOUT | M_LOIN | M_RUN, '0, '0, '0);
    add_v(1'b0, i_mul, 1'b1, M_ZHIGHOUT | M_HIIN | M_RUN, '0, '0, '0);

    // st r4 with mem_done low in T6 (ignored) and one write wait in T7
    add_fetch(i_st, 1);
    add_v(1'b0, i_st, 1'b0, M_YIN | M_RUN, '0, bit16(8), '0);
    add_v(1'b0, i_st, 1'b0, M_COUT | M_ZLOWIN | M_RUN, '0, '0, 5'b00011);
    add_v(1'b0, i_st, 1'b0, M_ZLOWOUT | M_MARIN | M_RUN, '0, '0, '0);
    add_v(1'b0, i_st, 1'b0, M_MDRIN | M_RUN, '0, bit16(4), '0);
    add_v(1'b0, i_st, 1'b0, M_MEMWRITE | M_RUN, '0, '0, '0);
    add_v(1'b0, i_st, 1'b1, M_MEMWRITE | M_RUN, '0, '0, '0);

    // neg r3 = -r11
    add_fetch(i_neg, 0);
    add_v(1'b0, i_neg, 1'b1, M_ZLOWIN | M_RUN, '0, bit16(11), 5'b10000);
    add_v(1'b0, i_neg, 1'b1, M_ZLOWOUT | M_RUN, bit16(3), '0, '0);

    // andi r2 = r13 & C
    add_fetch(i_andi, 0);
    add_v(1'b0, i_andi, 1'b1, M_YIN | M_RUN, '0, bit16(13), '0);
    add_v(1'b0, i_andi, 1'b1, M_COUT | M_ZLOWIN | M_RUN, '0, '0, 5'b00101);
    add_v(1'b0, i_andi, 1'b1, M_ZLOWOUT | M_RUN, bit16(2), '0, '0);

    // ror r15 = r0 ror r14 (edge register numbers)
    add_fetch(i_ror, 0);
    add_v(1'b0, i_ror, 1'b1, M_YIN | M_RUN, '0, bit16(0), '0);
    add_v(1'b0, i_ror, 1'b1, M_ZLOWIN | M_RUN, '0, bit16(14), 5'b01001);
    add_v(1'b0, i_ror, 1'b1, M_ZLOWOUT | M_RUN, bit16(15), '0, '0);

    // nop, then undefined opcode, then halt
    add_fetch(i_nop, 0);
    add_v(1'b0, i_nop, 1'b1, M_RUN, '0, '0, '0);
    add_fetch(i_ill, 0);
    add_v(1'b0, i_ill, 1'b1, M_ILLEGAL | M_RUN, '0, '0, '0);
    add_fetch(i_halt, 0);
    add_v(1'b0, i_halt, 1'b1, M_RUN, '0, '0, '0);
    for (int k = 0; k < 20; k++) add_v(1'b0, i_halt, 1'(k % 2), '0, '0, '0, '0);

    // Apply table: drive on falling edge, check 1 time unit later
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      clr = tbl[k].clr;
      ir = tbl[k].ir;
      mem_done = tbl[k].md;
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].sig, tbl[k].rin, tbl[k].rout, tbl[k].alu);
    end

    // clr leaves HALT and restarts at T0
    @(negedge clk);
    clr = 1'b1; ir = i_add; mem_done = 1'b0;
    #1 check_all("halt_clr", '0, '0, '0, '0);
    @(negedge clk);
    clr = 1'b0;
    #1 check_all("restart_t0", S_T0, '0, '0, '0);
    @(negedge clk);
    #1 check_all("wait_t1", S_T1, '0, '0, '0);

    // clr raised mid-cycle during the T1 wait blanks outputs at once
    @(posedge clk);
    #2 check_all("still_t1", S_T1, '0, '0, '0);
    clr = 1'b1;
    #1 check_all("clr_in_wait", '0, '0, '0, '0);

    @(negedge clk);
    clr = 1'b0; mem_done = 1'b1;
    #1 check_all("after_clr_t0", S_T0, '0, '0, '0);

    // Zero-wait fetch: IRin appears two cycles after T0, bounded search
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      #1;
      n++;
      if (IRin) break;
    end
    check("irin_latency", 32'(n), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
